spi_flash_fetch: RTL

- Instruction-fetch front end that sits directly upstream of rv32e_core's instruction port.
- Converts 32-bit word fetch requests into SPI-mode-0 READ (0x03) transactions to an external serial flash, and returns the assembled instruction word with a one-cycle valid strobe.
- Keeps chip-select asserted between words, so sequential fetches stream without re-issuing command and address.

---
 rtl/spi_flash_fetch.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_fetch.sv
// spi_flash_fetch
// Instruction-fetch front end for rv32e_core. Each 32-bit word fetch request
// becomes an SPI mode-0 READ transaction to a serial flash. Chip select stays
// low after a word, so a fetch of the next sequential word only clocks in
// another 32 data bits without re-sending command and address.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   req_valid      fetch request, held with stable req_addr until rsp_valid
//   req_addr       byte address, only [23:2] is used
//   rsp_valid      one-cycle strobe, rsp_data valid in the same cycle
//   rsp_data       fetched word, little-endian byte assembly
//   busy           high in every state except IDLE and HOLD
//   spi_sclk       SPI clock, idles low
//   spi_cs_n       SPI chip select, active low
//   spi_mosi       SPI serial out, changes while sclk is low
//   spi_miso       SPI serial in, sampled on the clk edge that raises sclk
module spi_flash_fetch #(
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned CS_HIGH  = 2,
  parameter int unsigned MAX_HOLD = 16,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(CS_HIGH + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_HIGH - 1);
  localparam logic [GW-1:0] GAP_SAT   = GW'(CS_HIGH);

  typedef enum logic [2:0] {IDLE, CSGAP, START, CMD, DATA, HOLD} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] divCnt_q, divCnt_d;
  logic          sclk_q, sclk_d;
  logic [4:0]    bitCnt_q, bitCnt_d;
  logic [31:0]   txShift_q, txShift_d;
  logic [31:0]   rxShift_q, rxShift_d;
  logic          rspValid_q, rspValid_d;
  logic [31:0]   rspData_q, rspData_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic [GW-1:0] gapCnt_q, gapCnt_d;
  logic [21:0]   lastAddr_q, lastAddr_d;
  logic          lastValid_q, lastValid_d;

  logic halfEnd;
  logic gapDone;
  logic seqHit;
  logic unusedAddrBits;

  assign halfEnd        = (divCnt_q == DIV_LAST);
  assign gapDone        = (gapCnt_q >= GAP_LAST);
  assign seqHit         = lastValid_q && (req_addr[23:2] == lastAddr_q + 22'd1);
  assign unusedAddrBits = ^{req_addr[31:24], req_addr[1:0]};

  // Chip select, mosi and busy are decoded straight from the registered state,
  // so an asynchronous reset releases the flash in the very same cycle.
  assign spi_cs_n  = !(state_q inside {START, CMD, DATA, HOLD});
  assign spi_mosi  = (state_q == START || state_q == CMD) && txShift_q[31];
  assign busy      = !(state_q == IDLE || state_q == HOLD);
  assign spi_sclk  = sclk_q;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;

  // State register and datapath registers; everything returns to idle
  // immediately on reset, with the CS-high gap counted as already satisfied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      divCnt_q    <= '0;
      sclk_q      <= 1'b0;
      bitCnt_q    <= '0;
      txShift_q   <= '0;
      rxShift_q   <= '0;
      rspValid_q  <= 1'b0;
      rspData_q   <= '0;
      holdCnt_q   <= '0;
      gapCnt_q    <= GAP_SAT;
      lastAddr_q  <= '0;
      lastValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      divCnt_q    <= divCnt_d;
      sclk_q      <= sclk_d;
      bitCnt_q    <= bitCnt_d;
      txShift_q   <= txShift_d;
      rxShift_q   <= rxShift_d;
      rspValid_q  <= rspValid_d;
      rspData_q   <= rspData_d;
      holdCnt_q   <= holdCnt_d;
      gapCnt_q    <= gapCnt_d;
      lastAddr_q  <= lastAddr_d;
      lastValid_q <= lastValid_d;
    end
  end

  // Next-state logic. Each SPI bit is a low half then a high half of CLK_DIV
  // cycles; the edge ending a low half raises sclk (and samples miso in DATA),
  // the edge ending a high half drops sclk and moves to the next bit.
  // gapCnt counts cycles with cs_n high so CS_HIGH is honoured before START.
  // Requests in HOLD are ignored while rsp_valid is high, since the requester
  // still holds the completed request during that cycle.
  always_comb begin
    state_d     = state_q;
    divCnt_d    = divCnt_q;
    sclk_d      = sclk_q;
    bitCnt_d    = bitCnt_q;
    txShift_d   = txShift_q;
    rxShift_d   = rxShift_q;
    rspValid_d  = 1'b0;
    rspData_d   = rspData_q;
    holdCnt_d   = holdCnt_q;
    gapCnt_d    = '0;
    lastAddr_d  = lastAddr_q;
    lastValid_d = lastValid_q;

    if (state_q == IDLE || state_q == CSGAP) begin
      gapCnt_d = (gapCnt_q == GAP_SAT) ? gapCnt_q : gapCnt_q + GW'(1);
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (gapDone) begin
            state_d   = START;
            txShift_d = {READ_CMD, req_addr[23:2], 2'b00};
          end else begin
            state_d = CSGAP;
          end
        end
      end
      CSGAP: begin
        if (gapDone) begin
          state_d   = START;
          txShift_d = {READ_CMD, req_addr[23:2], 2'b00};
        end
      end
      START: begin
        state_d  = CMD;
        divCnt_d = '0;
        sclk_d   = 1'b0;
        bitCnt_d = '0;
      end
      CMD, DATA: begin
        divCnt_d = halfEnd ? '0 : divCnt_q + DW'(1);
        if (halfEnd) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (state_q == DATA) begin
              rxShift_d = {rxShift_q[30:0], spi_miso};
            end
          end else begin
            sclk_d    = 1'b0;
            bitCnt_d  = bitCnt_q + 5'd1;
            txShift_d = {txShift_q[30:0], 1'b0};
            if (bitCnt_q == 5'd31) begin
              if (state_q == CMD) begin
                state_d = DATA;
              end else begin
                state_d     = HOLD;
                rspValid_d  = 1'b1;
                rspData_d   = {rxShift_q[7:0], rxShift_q[15:8],
                               rxShift_q[23:16], rxShift_q[31:24]};
                holdCnt_d   = '0;
                lastAddr_d  = req_addr[23:2];
                lastValid_d = 1'b1;
              end
            end
          end
        end
      end
      HOLD: begin
        holdCnt_d = holdCnt_q + HW'(1);
        if (req_valid && !rspValid_q) begin
          if (seqHit) begin
            state_d  = DATA;
            divCnt_d = '0;
            sclk_d   = 1'b0;
            bitCnt_d = '0;
          end else begin
            state_d     = CSGAP;
            lastValid_d = 1'b0;
          end
        end else if (holdCnt_q == HOLD_LAST) begin
          state_d     = IDLE;
          lastValid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
